fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch sequencer sitting directly upstream of the 32x14 `memoria` word store; it owns that memory's en/wr/address/datain pins.
- Run mode: steps a 5-bit program counter, reads one word per instruction, and presents it to the downstream decoder on a valid/ready handshake.
- Idle mode: a loader port writes program words into the memory.
- Stops on a HALT opcode.

Parameters:
- ADDR_W, 5, memory address / program counter width.
- DATA_W, 14, instruction word width.
- READ_LAT, 1, wait cycles between driving a read and sampling mem_dataout; legal 1..4.
- HALT_OP, 4'hF, value of instr[DATA_W-1:DATA_W-4] that halts fetching.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse; begins fetching from address 0.
- ld_valid  in  1  loader write request.
- ld_addr  in  ADDR_W  loader write address.
- ld_data  in  DATA_W  loader write data.
- ld_ready  out  1  loader write accepted this cycle.
- mem_en  out  1  to memory en.
- mem_wr  out  1  to memory wr.
- mem_addr  out  ADDR_W  to memory address.
- mem_datain  out  DATA_W  to memory datain.
- mem_dataout  in  DATA_W  from memory dataout.
- instr  out  DATA_W  fetched word, registered.
- instr_valid  out  1  instr holds a word not yet consumed.
- instr_ready  in  1  decoder accepts instr.
- branch_en  in  1  take branch_addr as next PC; sampled only on handshake.
- branch_addr  in  ADDR_W  branch target.
- pc  out  ADDR_W  address of the word currently in fetch/hold.
- busy  out  1  state is not IDLE and not HALTED.
- halted  out  1  HALT word has been consumed.

Behaviour:
- Reset (rst_n low, async): state=IDLE; pc=0, instr=0, wait counter=0; instr_valid=0, halted=0, busy=0.
- Reset drives mem_en=0 and mem_wr=0 immediately; no memory write may occur during reset.
- Reset mid-fetch aborts the fetch with no residual valid.
- States: IDLE, FETCH, WAIT, HOLD, HALTED.
- IDLE, loader: ld_ready=ld_valid (combinational). When ld_valid=1, mem_en=1, mem_wr=1, mem_addr=ld_addr, mem_datain=ld_data in the same cycle; state stays IDLE.
- IDLE, start: start=1 with ld_valid=0 sets pc<=0 and goes to FETCH.
- IDLE, simultaneous ld_valid and start: the load wins and start is ignored.
- Outside IDLE: ld_ready=0 and loader requests are dropped.
- FETCH (1 cycle): mem_en=1, mem_wr=0, mem_addr=pc, mem_datain=0; then WAIT with counter=READ_LAT-1.
- WAIT: mem_en=1, mem_wr=0, mem_addr=pc held.
  - Counter decrements each cycle.
  - In the cycle the counter reaches 0, instr<=mem_dataout and the state goes to HOLD.
- Latency: start asserted in cycle 0 gives instr_valid=1 in cycle 2+READ_LAT.
- HOLD: instr_valid=1, mem_en=0; instr and pc are stable until the handshake (instr_valid&instr_ready).
- On handshake, if the opcode equals HALT_OP: go to HALTED; instr_valid<=0; pc unchanged.
- On handshake, otherwise:
  - pc<=branch_en ? branch_addr : pc+1, with wrap 31->0 (modulo 2^ADDR_W, no flag).
  - Go to FETCH.
- Back-to-back handshakes give one instruction per 2+READ_LAT cycles.
- branch_en outside a handshake cycle is ignored.
- HALTED: halted=1, mem_en=0. start=1 clears halted, sets pc<=0 and goes to FETCH. The loader is not served.
- Default (IDLE without ld_valid, HALTED, HOLD): mem_en=0, mem_wr=0, mem_addr=pc, mem_datain=0.
- mem_wr=1 only in IDLE with ld_valid=1.

Test Plan:
- Reset, then in IDLE load addr 0..2 = 14'h0011, 14'h0022, 14'h3C00; pulse start; hold instr_ready=1 -> instr_valid in cycles 3, 6, 9 (READ_LAT=1). instr sequence 0011, 0022, 3C00, then halted=1 and pc=2; mem_wr never 1 after start.
- Backpressure: instr_ready=0 for 5 cycles in HOLD -> instr and pc stable, mem_en=0, single handshake when ready rises, no word lost or duplicated.
- Branch: handshake at pc=1 with branch_en=1, branch_addr=5'd20 -> next mem_addr=20. branch_en pulsed outside handshake -> pc=2 follows normally.
- Wrap: branch to 31, word at 31 non-HALT, handshake -> pc=0 and fetch of address 0.
- Simultaneous: ld_valid and start in the same IDLE cycle -> write occurs, state stays IDLE. ld_valid while busy -> ld_ready=0, memory word unchanged on readback.
- Reset mid-WAIT with READ_LAT=3 -> outputs cleared asynchronously, no instr_valid. Start after restart returns the word at address 0 at cycle 5.

Source files
------------

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction-fetch sequencer in front of a 32x14 single-port word store.
//   It owns the memory's en/wr/address/datain pins.
//   - Idle mode: a loader port writes program words straight into the memory.
//   - Run mode: steps a program counter, reads one word per instruction and
//     presents it downstream on a valid/ready handshake.
//   - A consumed word whose top nibble equals HALT_OP stops fetching.
//
// Ports
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_start               pulse: begin fetching at address 0 (from IDLE/HALTED)
//   i_ld_valid/addr/data  loader write request (served only in IDLE)
//   o_ld_ready            loader write accepted this cycle
//   o_mem_en/wr/addr/     memory control and write data
//   o_mem_datain
//   i_mem_dataout         memory read data
//   o_instr/o_instr_valid fetched word and its valid flag (registered)
//   i_instr_ready         decoder accepts o_instr
//   i_branch_en/addr      next-PC override, sampled only on a handshake
//   o_pc                  address of the word in fetch/hold
//   o_busy                fetching (FETCH, WAIT or HOLD)
//   o_halted              HALT word has been consumed
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int         ADDR_W   = 5,
    parameter int         DATA_W   = 14,
    parameter int         READ_LAT = 1,
    parameter logic [3:0] HALT_OP  = 4'hF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_ld_valid,
    input  logic [ADDR_W-1:0] i_ld_addr,
    input  logic [DATA_W-1:0] i_ld_data,
    output logic              o_ld_ready,
    output logic              o_mem_en,
    output logic              o_mem_wr,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_datain,
    input  logic [DATA_W-1:0] i_mem_dataout,
    output logic [DATA_W-1:0] o_instr,
    output logic              o_instr_valid,
    input  logic              i_instr_ready,
    input  logic              i_branch_en,
    input  logic [ADDR_W-1:0] i_branch_addr,
    output logic [ADDR_W-1:0] o_pc,
    output logic              o_busy,
    output logic              o_halted
);

    // Wait counter wide enough for READ_LAT up to 4 (counts READ_LAT-1 .. 0).
    localparam int                CNT_W    = 3;
    localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(READ_LAT - 1);
    localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] PC_ZERO  = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] PC_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_WAIT   = 3'd2,
        S_HOLD   = 3'd3,
        S_HALTED = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [DATA_W-1:0] r_instr;
    logic [DATA_W-1:0] w_instr_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              r_instr_valid;
    logic              r_busy;
    logic              r_halted;
    logic              w_handshake;
    logic              w_is_halt;

    // instr_valid is only ever set in HOLD, so this is the HOLD handshake.
    assign w_handshake = r_instr_valid & i_instr_ready;
    assign w_is_halt   = (r_instr[DATA_W-1 -: 4] == HALT_OP);

    // Next-state and datapath next values for the fetch sequencer.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_instr_nxt = r_instr;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                // A pending load takes priority over start.
                if (i_ld_valid) begin
                    w_state_nxt = S_IDLE;
                end else if (i_start) begin
                    w_state_nxt = S_FETCH;
                    w_pc_nxt    = PC_ZERO;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_FETCH: begin
                w_state_nxt = S_WAIT;
                w_cnt_nxt   = CNT_INIT;
            end
            S_WAIT: begin
                if (r_cnt == CNT_ZERO) begin
                    w_instr_nxt = i_mem_dataout;
                    w_state_nxt = S_HOLD;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end
            S_HOLD: begin
                if (w_handshake) begin
                    if (w_is_halt) begin
                        w_state_nxt = S_HALTED;
                    end else begin
                        // Plain ADDR_W-bit add wraps the last address to 0.
                        w_pc_nxt    = i_branch_en ? i_branch_addr : (r_pc + PC_ONE);
                        w_state_nxt = S_FETCH;
                    end
                end else begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_HALTED: begin
                if (i_start) begin
                    w_state_nxt = S_FETCH;
                    w_pc_nxt    = PC_ZERO;
                end else begin
                    w_state_nxt = S_HALTED;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_pc_nxt    = PC_ZERO;
                w_cnt_nxt   = CNT_ZERO;
                w_instr_nxt = DATA_ZERO;
            end
        endcase
    end

    // Memory pins and loader acknowledge; forced inactive while reset is held
    // so a loader request can never write during reset.
    always_comb begin
        o_ld_ready   = 1'b0;
        o_mem_en     = 1'b0;
        o_mem_wr     = 1'b0;
        o_mem_addr   = r_pc;
        o_mem_datain = DATA_ZERO;
        if (!i_rst_n) begin
            o_ld_ready   = 1'b0;
            o_mem_en     = 1'b0;
            o_mem_wr     = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_ld_valid) begin
                        o_ld_ready   = 1'b1;
                        o_mem_en     = 1'b1;
                        o_mem_wr     = 1'b1;
                        o_mem_addr   = i_ld_addr;
                        o_mem_datain = i_ld_data;
                    end else begin
                        o_ld_ready   = 1'b0;
                    end
                end
                S_FETCH, S_WAIT: begin
                    o_mem_en = 1'b1;
                end
                default: begin
                    o_mem_en = 1'b0;
                end
            endcase
        end
    end

    // State, datapath and status-flag registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_pc          <= PC_ZERO;
            r_instr       <= DATA_ZERO;
            r_cnt         <= CNT_ZERO;
            r_instr_valid <= 1'b0;
            r_busy        <= 1'b0;
            r_halted      <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_instr       <= w_instr_nxt;
            r_cnt         <= w_cnt_nxt;
            // Flags follow the next state so they line up with it exactly.
            r_instr_valid <= (w_state_nxt == S_HOLD);
            r_busy        <= (w_state_nxt == S_FETCH) || (w_state_nxt == S_WAIT) ||
                             (w_state_nxt == S_HOLD);
            r_halted      <= (w_state_nxt == S_HALTED);
        end
    end

    assign o_instr       = r_instr;
    assign o_instr_valid = r_instr_valid;
    assign o_pc          = r_pc;
    assign o_busy        = r_busy;
    assign o_halted      = r_halted;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Two fetch_unit instances (READ_LAT=1 and READ_LAT=3) share one stimulus
//   stream, each with its own behavioural memory whose read data emerges
//   READ_LAT cycles after the address is presented.  The READ_LAT=1 instance
//   is compared every cycle against a transaction-level model; directed
//   literal expectations pin both instances and the model.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        ld_valid;
    logic [4:0]  ld_addr;
    logic [13:0] ld_data;
    logic        instr_ready;
    logic        branch_en;
    logic [4:0]  branch_addr;

    logic        d1_ld_ready, d1_mem_en, d1_mem_wr, d1_instr_valid, d1_busy, d1_halted;
    logic [4:0]  d1_mem_addr, d1_pc;
    logic [13:0] d1_mem_datain, d1_mem_dataout, d1_instr;
    logic        d3_ld_ready, d3_mem_en, d3_mem_wr, d3_instr_valid, d3_busy, d3_halted;
    logic [4:0]  d3_mem_addr, d3_pc;
    logic [13:0] d3_mem_datain, d3_mem_dataout, d3_instr;

    int n_chk  = 0;
    int n_fail = 0;

    fetch_unit #(.ADDR_W(5), .DATA_W(14), .READ_LAT(1), .HALT_OP(4'hF)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
        .i_ld_valid(ld_valid), .i_ld_addr(ld_addr), .i_ld_data(ld_data),
        .o_ld_ready(d1_ld_ready), .o_mem_en(d1_mem_en), .o_mem_wr(d1_mem_wr),
        .o_mem_addr(d1_mem_addr), .o_mem_datain(d1_mem_datain),
        .i_mem_dataout(d1_mem_dataout), .o_instr(d1_instr),
        .o_instr_valid(d1_instr_valid), .i_instr_ready(instr_ready),
        .i_branch_en(branch_en), .i_branch_addr(branch_addr),
        .o_pc(d1_pc), .o_busy(d1_busy), .o_halted(d1_halted)
    );

    fetch_unit #(.ADDR_W(5), .DATA_W(14), .READ_LAT(3), .HALT_OP(4'hF)) dut3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
        .i_ld_valid(ld_valid), .i_ld_addr(ld_addr), .i_ld_data(ld_data),
        .o_ld_ready(d3_ld_ready), .o_mem_en(d3_mem_en), .o_mem_wr(d3_mem_wr),
        .o_mem_addr(d3_mem_addr), .o_mem_datain(d3_mem_datain),
        .i_mem_dataout(d3_mem_dataout), .o_instr(d3_instr),
        .o_instr_valid(d3_instr_valid), .i_instr_ready(instr_ready),
        .i_branch_en(branch_en), .i_branch_addr(branch_addr),
        .o_pc(d3_pc), .o_busy(d3_busy), .o_halted(d3_halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural memories ----------------
    logic [13:0] mem1 [32];
    logic [13:0] mem3 [32];
    logic [13:0] p3   [3];

    always @(posedge clk) begin
        if (d1_mem_en && d1_mem_wr) mem1[d1_mem_addr] <= d1_mem_datain;
        d1_mem_dataout <= (d1_mem_en && !d1_mem_wr) ? mem1[d1_mem_addr] : 14'h0;
    end

    always @(posedge clk) begin
        if (d3_mem_en && d3_mem_wr) mem3[d3_mem_addr] <= d3_mem_datain;
        p3[0] <= (d3_mem_en && !d3_mem_wr) ? mem3[d3_mem_addr] : 14'h0;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign d3_mem_dataout = p3[2];

    // ---------------- reference model (READ_LAT = 1) ----------------
    // mode: 0 idle, 1 running, 2 halted.  k counts cycles since the fetch of
    // the current word began: k = 0..LAT memory is read, k = LAT the word is
    // captured, k > LAT the word is on offer.
    localparam int LAT = 1;
    int          m_mode;
    int          m_k;
    logic [4:0]  m_pc;
    logic [13:0] m_instr;
    logic [13:0] m_mem [32];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode  <= 0;
            m_k     <= 0;
            m_pc    <= 5'd0;
            m_instr <= 14'h0;
        end else if (m_mode == 0) begin
            if (ld_valid) m_mem[ld_addr] <= ld_data;
            else if (start) begin
                m_mode <= 1; m_k <= 0; m_pc <= 5'd0;
            end
        end else if (m_mode == 1) begin
            if (m_k < LAT) m_k <= m_k + 1;
            else if (m_k == LAT) begin
                m_instr <= m_mem[m_pc];
                m_k     <= m_k + 1;
            end else if (instr_ready) begin
                if (m_instr[13:10] == 4'hF) m_mode <= 2;
                else begin
                    m_pc <= branch_en ? branch_addr : m_pc + 5'd1;
                    m_k  <= 0;
                end
            end
        end else begin
            if (start) begin
                m_mode <= 1; m_k <= 0; m_pc <= 5'd0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of the READ_LAT=1 instance against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            logic ld_now;
            ld_now = (m_mode == 0) && ld_valid;
            chk("cyc ld_ready",    32'(d1_ld_ready),    32'(ld_now));
            chk("cyc mem_wr",      32'(d1_mem_wr),      32'(ld_now));
            chk("cyc mem_en",      32'(d1_mem_en),      32'(ld_now || (m_mode == 1 && m_k <= LAT)));
            chk("cyc mem_addr",    32'(d1_mem_addr),    32'(ld_now ? ld_addr : m_pc));
            chk("cyc mem_datain",  32'(d1_mem_datain),  32'(ld_now ? ld_data : 14'h0));
            chk("cyc instr_valid", 32'(d1_instr_valid), 32'(m_mode == 1 && m_k > LAT));
            chk("cyc instr",       32'(d1_instr),       32'(m_instr));
            chk("cyc pc",          32'(d1_pc),          32'(m_pc));
            chk("cyc busy",        32'(d1_busy),        32'(m_mode == 1));
            chk("cyc halted",      32'(d1_halted),      32'(m_mode == 2));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic load(input logic [4:0] a, input logic [13:0] d);
        ld_valid = 1'b1; ld_addr = a; ld_data = d;
        #1;
        chk("load ld_ready", 32'(d1_ld_ready), 32'd1);
        chk("load mem_wr",   32'(d1_mem_wr),   32'd1);
        tick();
        ld_valid = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 12; i++) begin
            if (d1_instr_valid) break;
            tick();
        end
        chk(name, 32'(d1_instr_valid), 32'd1);
    endtask

    task automatic handshake(input logic br, input logic [4:0] ba, input logic [4:0] exp_addr);
        branch_en = br; branch_addr = ba; instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0; branch_en = 1'b0;
        chk("hs mem_addr",    32'(d1_mem_addr),    32'(exp_addr));
        chk("hs mem_en",      32'(d1_mem_en),      32'd1);
        chk("hs instr_valid", 32'(d1_instr_valid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; instr_ready = 1'b0;
        branch_en = 1'b0; branch_addr = 5'd0;
        // Loader request during reset must not reach the memory.
        ld_valid = 1'b1; ld_addr = 5'd7; ld_data = 14'h3FFF;
        #2;
        chk("rst mem_wr",      32'(d1_mem_wr),      32'd0);
        chk("rst mem_en",      32'(d1_mem_en),      32'd0);
        chk("rst ld_ready",    32'(d1_ld_ready),    32'd0);
        chk("rst instr_valid", 32'(d1_instr_valid), 32'd0);
        chk("rst busy",        32'(d1_busy),        32'd0);
        chk("rst halted",      32'(d1_halted),      32'd0);
        chk("rst pc",          32'(d1_pc),          32'd0);
        chk("rst instr",       32'(d1_instr),       32'd0);
        chk("rst3 mem_wr",     32'(d3_mem_wr),      32'd0);
        ld_valid = 1'b0;
        tick();
        rst_n = 1'b1;

        // --- Test 1: short program ending in HALT, decoder always ready ---
        load(5'd0, 14'h0011);
        load(5'd1, 14'h0022);
        load(5'd2, 14'h3C00);
        instr_ready = 1'b1;
        start = 1'b1;
        tick();                     // cycle 1
        start = 1'b0;
        tick(); tick();             // cycle 3
        chk("t1 valid c3", 32'(d1_instr_valid), 32'd1);
        chk("t1 instr c3", 32'(d1_instr),       32'h0011);
        chk("t1 pc c3",    32'(d1_pc),          32'd0);
        chk("t1 model c3", 32'(m_instr),        32'h0011);
        tick(); tick();             // cycle 5
        chk("t1 valid c5", 32'(d1_instr_valid), 32'd0);
        tick();                     // cycle 6
        chk("t1 instr c6", 32'(d1_instr),       32'h0022);
        chk("t1 pc c6",    32'(d1_pc),          32'd1);
        tick(); tick(); tick();     // cycle 9
        chk("t1 valid c9", 32'(d1_instr_valid), 32'd1);
        chk("t1 instr c9", 32'(d1_instr),       32'h3C00);
        tick();                     // cycle 10
        chk("t1 halted",   32'(d1_halted),      32'd1);
        chk("t1 pc halt",  32'(d1_pc),          32'd2);
        chk("t1 busy",     32'(d1_busy),        32'd0);
        chk("t1 model",    32'(m_mode),         32'd2);
        instr_ready = 1'b0;
        tick(); tick(); tick(); tick(); tick();

        // --- Test 2: backpressure, branches, wrap ---
        do_reset();
        load(5'd0,  14'h0101);
        load(5'd1,  14'h0202);
        load(5'd20, 14'h0A14);
        load(5'd21, 14'h0B15);
        load(5'd31, 14'h0B1F);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_valid("t2 first valid");
        branch_en = 1'b1; branch_addr = 5'd9;   // not a handshake: ignored
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp instr",  32'(d1_instr),       32'h0101);
            chk("bp pc",     32'(d1_pc),          32'd0);
            chk("bp mem_en", 32'(d1_mem_en),      32'd0);
            chk("bp valid",  32'(d1_instr_valid), 32'd1);
        end
        branch_en = 1'b0;
        handshake(1'b0, 5'd0, 5'd1);
        wait_valid("t2 w1 valid");
        chk("t2 instr w1", 32'(d1_instr), 32'h0202);
        handshake(1'b1, 5'd20, 5'd20);
        wait_valid("t2 w20 valid");
        chk("t2 instr w20", 32'(d1_instr), 32'h0A14);
        branch_en = 1'b1; branch_addr = 5'd9;
        tick();
        branch_en = 1'b0;
        handshake(1'b0, 5'd0, 5'd21);
        wait_valid("t2 w21 valid");
        chk("t2 pc w21", 32'(d1_pc), 32'd21);
        handshake(1'b1, 5'd31, 5'd31);
        wait_valid("t2 w31 valid");
        chk("t2 instr w31", 32'(d1_instr), 32'h0B1F);
        handshake(1'b0, 5'd0, 5'd0);
        chk("t2 wrap pc", 32'(d1_pc), 32'd0);
        wait_valid("t2 wrap valid");
        chk("t2 wrap instr", 32'(d1_instr), 32'h0101);

        // --- Test 3: load vs start collision, loader dropped while busy ---
        do_reset();
        ld_valid = 1'b1; ld_addr = 5'd5; ld_data = 14'h1234; start = 1'b1;
        #1;
        chk("t3 collide ld_ready", 32'(d1_ld_ready), 32'd1);
        tick();
        ld_valid = 1'b0; start = 1'b0;
        chk("t3 still idle", 32'(d1_busy), 32'd0);
        tick();
        chk("t3 idle again", 32'(d1_busy), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        ld_valid = 1'b1; ld_addr = 5'd5; ld_data = 14'h3FFF;
        #1;
        chk("t3 busy ld_ready", 32'(d1_ld_ready), 32'd0);
        chk("t3 busy mem_wr",   32'(d1_mem_wr),   32'd0);
        wait_valid("t3 w0 valid");
        ld_valid = 1'b0;
        handshake(1'b1, 5'd5, 5'd5);
        wait_valid("t3 w5 valid");
        chk("t3 readback", 32'(d1_instr), 32'h1234);

        // --- Test 4: reset in the middle of a READ_LAT=3 wait ---
        do_reset();
        start = 1'b1;
        tick();                     // cycle 1
        start = 1'b0;
        tick();                     // cycle 2: dut3 waiting
        chk("t4 busy pre",   32'(d3_busy),   32'd1);
        chk("t4 mem_en pre", 32'(d3_mem_en), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t4 rst valid",  32'(d3_instr_valid), 32'd0);
        chk("t4 rst busy",   32'(d3_busy),        32'd0);
        chk("t4 rst mem_en", 32'(d3_mem_en),      32'd0);
        chk("t4 rst pc",     32'(d3_pc),          32'd0);
        chk("t4 rst d1 en",  32'(d1_mem_en),      32'd0);
        tick();
        rst_n = 1'b1;
        tick(); tick(); tick();
        chk("t4 no residual", 32'(d3_instr_valid), 32'd0);
        start = 1'b1;
        tick();                     // cycle 1
        start = 1'b0;
        tick(); tick(); tick();     // cycle 4
        chk("t4 valid c4", 32'(d3_instr_valid), 32'd0);
        tick();                     // cycle 5
        chk("t4 valid c5", 32'(d3_instr_valid), 32'd1);
        chk("t4 instr c5", 32'(d3_instr),       32'h0101);
        chk("t4 pc c5",    32'(d3_pc),          32'd0);
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
